// File: rtl/sha256_pkg.sv
// Shared constants and FSM encoding for the sha256 core arbiter.
package sha256_pkg;

  localparam int unsigned D_WIDTH = 32;
  localparam int unsigned O_COUNT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sha256_arb_rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [IW-1:0]    gnt_idx_o,
  output logic             any_o
);

  logic          w_found;
  logic [IW-1:0] w_idx;

  always_comb begin
    gnt_idx_o = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      w_idx = IW'((32'(ptr_i) + i) % N_REQ);
      if (!w_found && req_i[w_idx]) begin
        w_found   = 1'b1;
        gnt_idx_o = w_idx;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/sha256_arb.sv
// Shares one sha256 core among N_REQ requesters; a grant spans a whole
// message plus its O_COUNT digest words so nothing interleaves in the core.
module sha256_arb #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned D_WIDTH = sha256_pkg::D_WIDTH,
  parameter int unsigned O_COUNT = sha256_pkg::O_COUNT
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic [N_REQ-1:0][D_WIDTH-1:0]   req_data_i,
  input  logic [N_REQ-1:0]                req_last_i,
  input  logic [N_REQ-1:0]                req_valid_i,
  output logic [N_REQ-1:0]                req_ready_o,
  output logic [D_WIDTH-1:0]              rsp_data_o,
  output logic [N_REQ-1:0]                rsp_valid_o,
  input  logic [N_REQ-1:0]                rsp_ready_i,
  output logic [D_WIDTH-1:0]              core_in_data_o,
  output logic                            core_in_last_o,
  output logic                            core_in_valid_o,
  input  logic                            core_in_ready_i,
  input  logic [D_WIDTH-1:0]              core_out_data_i,
  input  logic                            core_out_valid_i,
  output logic                            core_out_ready_o,
  output logic [$clog2(N_REQ)-1:0]        gnt_o,
  output logic                            busy_o
);

  import sha256_pkg::*;

  localparam int unsigned GW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(O_COUNT);

  state_t        r_state;
  logic [GW-1:0] r_gnt;
  logic [GW-1:0] r_ptr;
  logic [CW-1:0] r_cnt;

  logic [GW-1:0] w_arb_idx;
  logic          w_arb_any;
  logic          w_in_fire;
  logic          w_out_fire;
  logic          w_last_out;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (GW)
  ) u_arb (
    .req_i     (req_valid_i),
    .ptr_i     (r_ptr),
    .gnt_idx_o (w_arb_idx),
    .any_o     (w_arb_any)
  );

  assign w_in_fire  = core_in_valid_o & core_in_ready_i;
  assign w_out_fire = core_out_valid_i & core_out_ready_o;
  assign w_last_out = (r_cnt == CW'(O_COUNT - 1));

  // Pointer starts at N_REQ-1 so requester 0 has top priority after reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ptr   <= GW'(N_REQ - 1);
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_arb_any) begin
            r_gnt   <= w_arb_idx;
            r_state <= FEED;
          end
        end
        FEED: begin
          if (w_in_fire && core_in_last_o) begin
            r_state <= DRAIN;
            r_cnt   <= '0;
          end
        end
        DRAIN: begin
          if (w_out_fire) begin
            if (w_last_out) begin
              r_state <= IDLE;
              r_ptr   <= r_gnt;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready_o      = '0;
    core_in_data_o   = '0;
    core_in_last_o   = 1'b0;
    core_in_valid_o  = 1'b0;
    rsp_data_o       = '0;
    rsp_valid_o      = '0;
    core_out_ready_o = 1'b0;
    case (r_state)
      FEED: begin
        core_in_data_o      = req_data_i[r_gnt];
        core_in_last_o      = req_last_i[r_gnt];
        core_in_valid_o     = req_valid_i[r_gnt];
        req_ready_o[r_gnt]  = core_in_ready_i;
      end
      DRAIN: begin
        rsp_data_o          = core_out_data_i;
        rsp_valid_o[r_gnt]  = core_out_valid_i;
        core_out_ready_o    = rsp_ready_i[r_gnt];
      end
      default: ;
    endcase
  end

  assign gnt_o  = r_gnt;
  assign busy_o = (r_state != IDLE);

endmodule

// File: tb/tb_sha256_arb.sv
// Bench for sha256_arb: behavioural sha256 core, requester sources/sinks,
// and a round-robin service-order model.
module tb_sha256_arb;

  localparam int unsigned N = 4;

  localparam logic [31:0] SHA_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [7:0][31:0] H_INIT = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };
  localparam logic [31:0] ABC_DIG [8] = '{
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };

  logic                clk_i = 1'b0;
  logic                rst_n_i;
  logic [N-1:0][31:0]  req_data_i;
  logic [N-1:0]        req_last_i, req_valid_i, req_ready_o;
  logic [31:0]         rsp_data_o;
  logic [N-1:0]        rsp_valid_o, rsp_ready_i;
  logic [31:0]         core_in_data_o, core_out_data_i;
  logic                core_in_last_o, core_in_valid_o, core_in_ready_i;
  logic                core_out_valid_i, core_out_ready_o;
  logic [1:0]          gnt_o;
  logic                busy_o;

  sha256_arb #(.N_REQ(N), .D_WIDTH(32), .O_COUNT(8)) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .req_data_i       (req_data_i),
    .req_last_i       (req_last_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .rsp_data_o       (rsp_data_o),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .core_in_data_o   (core_in_data_o),
    .core_in_last_o   (core_in_last_o),
    .core_in_valid_o  (core_in_valid_o),
    .core_in_ready_i  (core_in_ready_i),
    .core_out_data_i  (core_out_data_i),
    .core_out_valid_i (core_out_valid_i),
    .core_out_ready_o (core_out_ready_o),
    .gnt_o            (gnt_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  logic [31:0]       tx_q [N][$];
  logic [31:0]       rx_q [N][$];
  int                tx_idx [N];
  bit                pause [N];
  bit                is_abc [N];
  logic [7:0][31:0]  exp_dig [N];
  int                served_q [$];
  int                last_served;
  bit                gap_en, spur_en, tog;
  int                rsp_mode;

  int                cst, cwidx, coidx;
  logic [15:0][31:0] cblk;
  logic [7:0][31:0]  cH, cOut;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [7:0][31:0] compress(input logic [7:0][31:0] hin, input logic [15:0][31:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [7:0][31:0] hout;
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3))
           + w[i-7] + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    for (int i = 0; i < 8; i++) v[i] = hin[i];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + SHA_K[i] + w[i];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) hout[i] = hin[i] + v[i];
    return hout;
  endfunction

  function automatic logic [7:0][31:0] sha_msg(input logic [31:0] m [$]);
    logic [7:0][31:0]  h = H_INIT;
    logic [15:0][31:0] blk;
    for (int b = 0; b < m.size() / 16; b++) begin
      for (int i = 0; i < 16; i++) blk[i] = m[16*b + i];
      h = compress(h, blk);
    end
    return h;
  endfunction

  task automatic core_reset();
    cst = 0; cwidx = 0; coidx = 0; cH = H_INIT;
  endtask

  // Handshakes observed with pre-edge values; inputs are only driven on negedge.
  always @(posedge clk_i) begin
    if (!rst_n_i) begin
      core_reset();
    end else begin
      for (int k = 0; k < N; k++) begin
        if (req_valid_i[k] && req_ready_o[k] && tx_q[k].size() > 0) begin
          if (tx_idx[k] == 0) served_q.push_back(k);
          void'(tx_q[k].pop_front());
          tx_idx[k]++;
        end
        if (rsp_valid_o[k] && rsp_ready_i[k]) rx_q[k].push_back(rsp_data_o);
      end
      if (core_in_valid_o && core_in_ready_i && cst == 0) begin
        cblk[cwidx] = core_in_data_o;
        cwidx++;
        if (cwidx == 16) begin
          cH = compress(cH, cblk);
          cwidx = 0;
          if (core_in_last_o) begin
            cOut = cH; cH = H_INIT; cst = 1; coidx = 0;
          end
        end
      end
      if (core_out_valid_i && core_out_ready_o && cst == 1) begin
        coidx++;
        if (coidx == 8) cst = 0;
      end
    end
  end

  always @(negedge clk_i) begin
    tog = ~tog;
    for (int k = 0; k < N; k++) begin
      req_valid_i[k] = (tx_q[k].size() > 0) && !pause[k]
                     && !(gap_en && tx_idx[k] > 0 && $urandom_range(0, 3) == 0);
      req_data_i[k]  = (tx_q[k].size() > 0) ? tx_q[k][0] : $urandom;
      req_last_i[k]  = (tx_q[k].size() == 1);
      case (rsp_mode)
        0:       rsp_ready_i[k] = ($urandom_range(0, 2) != 0);
        1:       rsp_ready_i[k] = tog;
        default: rsp_ready_i[k] = 1'b1;
      endcase
    end
    core_in_ready_i = (cst == 0) && ($urandom_range(0, 3) != 0);
    if (cst == 1) begin
      core_out_valid_i = ($urandom_range(0, 4) != 0);
      core_out_data_i  = cOut[coidx];
    end else begin
      core_out_valid_i = spur_en && ($urandom_range(0, 3) == 0);
      core_out_data_i  = $urandom;
    end
    #1;
    if (rst_n_i) begin
      if (cst == 0 && core_out_valid_i)
        chk("spurious_out", {rsp_valid_o, core_out_ready_o, rsp_data_o}, '0);
      if (cst == 1 && rsp_mode == 1) begin
        chk("out_ready_follow", core_out_ready_o, rsp_ready_i[gnt_o]);
        chk("busy_in_drain", busy_o, 1);
      end
      if (busy_o) chk("other_lane_ready", req_ready_o & ~(4'b0001 << gnt_o), '0);
    end
  end

  task automatic launch(input int k, input bit abc, input int nblk);
    logic [31:0] m [$];
    m = {};
    if (abc) begin
      m.push_back(32'h61626380);
      repeat (14) m.push_back(32'h0);
      m.push_back(32'h00000018);
    end else begin
      for (int i = 0; i < 16 * nblk; i++) m.push_back($urandom);
    end
    exp_dig[k] = sha_msg(m);
    is_abc[k]  = abc;
    rx_q[k]    = {};
    tx_idx[k]  = 0;
    tx_q[k]    = m;
  endtask

  task automatic rr_order(input logic [N-1:0] mask, input int last, output int q [$]);
    q = {};
    for (int i = 1; i <= N; i++)
      if (mask[(last + i) % N]) q.push_back((last + i) % N);
  endtask

  task automatic wait_done(input logic [N-1:0] mask, input string tag);
    bit done = 0;
    for (int c = 0; c < 5000 && !done; c++) begin
      @(posedge clk_i); #2;
      done = !busy_o;
      for (int k = 0; k < N; k++)
        if (mask[k] && (rx_q[k].size() < 8 || tx_q[k].size() > 0)) done = 0;
    end
    chk({tag, "_timeout"}, done, 1);
    repeat (4) @(posedge clk_i);
    #2;
  endtask

  task automatic check_round(input logic [N-1:0] mask, input int exp_q [$]);
    chk("order_len", served_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < served_q.size(); i++)
      chk($sformatf("order_%0d", i), served_q[i], exp_q[i]);
    for (int k = 0; k < N; k++) begin
      if (mask[k]) begin
        chk($sformatf("rx_count_l%0d", k), rx_q[k].size(), 8);
        for (int i = 0; i < 8 && i < rx_q[k].size(); i++)
          chk($sformatf("digest_l%0d_w%0d", k, i), rx_q[k][i],
              is_abc[k] ? ABC_DIG[i] : exp_dig[k][i]);
      end
    end
    chk("idle_after", busy_o, 0);
    served_q = {};
    if (exp_q.size() > 0) last_served = exp_q[exp_q.size() - 1];
  endtask

  task automatic run_round(input logic [N-1:0] mask, input bit abc, input string tag);
    int q [$];
    for (int k = 0; k < N; k++)
      if (mask[k]) launch(k, abc, $urandom_range(1, 2));
    rr_order(mask, last_served, q);
    wait_done(mask, tag);
    check_round(mask, q);
  endtask

  initial begin
    int q [$];
    bit hit;
    rst_n_i = 1'b0;
    req_data_i = '0; req_last_i = '0; req_valid_i = '0; rsp_ready_i = '0;
    core_in_ready_i = 1'b0; core_out_valid_i = 1'b0; core_out_data_i = '0;
    for (int k = 0; k < N; k++) begin
      pause[k] = 0; tx_idx[k] = 0; is_abc[k] = 0;
    end
    gap_en = 0; spur_en = 1; tog = 0; rsp_mode = 2;
    last_served = N - 1;
    core_reset();

    repeat (3) @(posedge clk_i);
    #2;
    chk("rst_busy", busy_o, 0);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_outs", {req_ready_o, rsp_valid_o, rsp_data_o, core_in_valid_o, core_out_ready_o}, '0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    run_round(4'b0111, 1, "abc_012");
    run_round(4'b0001, 1, "abc_0");
    run_round(4'b1000, 0, "solo_3");
    rsp_mode = 1;
    run_round(4'b1010, 0, "pair_13");
    rsp_mode = 2;

    launch(2, 0, 2);
    hit = 0;
    for (int c = 0; c < 2000 && !hit; c++) begin
      @(posedge clk_i); #2;
      hit = (tx_idx[2] >= 5);
    end
    chk("pause_reach_timeout", hit, 1);
    launch(0, 0, 1);
    pause[2] = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); #2;
      chk($sformatf("pause_in_valid_%0d", i), core_in_valid_o, 0);
      chk($sformatf("pause_other_ready_%0d", i), req_ready_o & 4'b1011, '0);
    end
    pause[2] = 0;
    wait_done(4'b0101, "pause");
    q = {2, 0};
    check_round(4'b0101, q);

    gap_en = 1; rsp_mode = 0;
    for (int r = 0; r < 6; r++)
      run_round(4'($urandom_range(1, 15)), 0, $sformatf("rand_%0d", r));
    gap_en = 0; rsp_mode = 2;

    launch(0, 1, 1);
    hit = 0;
    for (int c = 0; c < 2000 && !hit; c++) begin
      @(posedge clk_i); #2;
      hit = (rx_q[0].size() >= 3);
    end
    chk("drain3_timeout", hit, 1);
    rst_n_i = 1'b0;
    #1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_gnt", gnt_o, 0);
    chk("mid_rst_outs", {req_ready_o, rsp_valid_o, rsp_data_o, core_in_valid_o, core_out_ready_o}, '0);
    for (int k = 0; k < N; k++) begin
      tx_q[k] = {}; rx_q[k] = {}; tx_idx[k] = 0;
    end
    served_q = {};
    core_reset();
    last_served = N - 1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    run_round(4'b1111, 1, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_arb.md
Name: sha256_arb

Overview:
- Round-robin arbiter and sequencer that shares one sha256 core between N_REQ independent message requesters.
- Each requester streams 32-bit message words (already padded) with a last flag and receives the 8-word digest back.
- The grant is held from the first accepted word through the 8th digest word, so messages never interleave in the core.
- Sits between requester-side valid/ready streams and the sha256 core's in_*/out_* ports.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- D_WIDTH, 32, word width; must match the core.
- O_COUNT, 8, digest words per message.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- req_data_i  in  N_REQ x D_WIDTH  message word per requester.
- req_last_i  in  N_REQ  final word of message.
- req_valid_i  in  N_REQ  word valid.
- req_ready_o  out  N_REQ  word accepted.
- rsp_data_o  out  D_WIDTH  digest word (shared bus, qualified per requester).
- rsp_valid_o  out  N_REQ  digest word valid for that requester.
- rsp_ready_i  in  N_REQ  requester accepts digest word.
- core_in_data_o  out  D_WIDTH  to core in_data_i.
- core_in_last_o  out  1  to core in_last_i.
- core_in_valid_o  out  1  to core in_valid_i.
- core_in_ready_i  in  1  from core in_ready_o.
- core_out_data_i  in  D_WIDTH  from core out_data_o.
- core_out_valid_i  in  1  from core out_valid_o.
- core_out_ready_o  out  1  to core out_ready_i.
- gnt_o  out  $clog2(N_REQ)  current grant index.
- busy_o  out  1  high when not IDLE.

Behaviour:
- Reset (async assert, sync deassert use):
  - state=IDLE, gnt_o=0, busy_o=0, word counter=0.
  - Round-robin pointer = N_REQ-1, so requester 0 wins first.
  - All valid/ready outputs are 0; rsp_data_o is 0.
- FSM states IDLE, FEED, DRAIN.
- IDLE:
  - No pass-through: req_ready_o=0, core_in_valid_o=0, core_out_ready_o=0.
  - If any req_valid_i is high, pick the first set bit searching from pointer+1 with wrap, register it into gnt_o, and go to FEED.
  - Latency is 1 cycle from req_valid_i to the first possible accept; the word is not consumed in IDLE.
- FEED:
  - Combinational pass-through of the granted lane: core_in_data_o/last_o/valid_o = req_*[gnt]; req_ready_o[gnt] = core_in_ready_i; other lanes' ready = 0.
  - On core_in_valid_o & core_in_ready_i & core_in_last_o, go to DRAIN and clear the counter.
  - core_out_ready_o=0. A spurious core_out_valid_i is ignored and not forwarded.
- DRAIN:
  - rsp_data_o = core_out_data_i; rsp_valid_o[gnt] = core_out_valid_i; core_out_ready_o = rsp_ready_i[gnt]; core_in_valid_o=0.
  - Each out handshake increments the counter.
  - The handshake at counter==O_COUNT-1 returns to IDLE and sets pointer=gnt.
- Arbitration:
  - Decided only in IDLE; requests that arrive mid-message wait.
  - The last-served requester has lowest priority next round.
  - The granted requester dropping req_valid_i mid-message stalls FEED with no timeout; the grant is held.
- Simultaneous events: the last word of requester A and a new req_valid_i from B cause no early grant; B is considered in the IDLE cycle after A's DRAIN.
- Back-to-back: minimum of 1 IDLE cycle between messages.
- Counter width is $clog2(O_COUNT); no wrap beyond O_COUNT-1.
- Reset mid-operation: everything returns to reset values immediately. The core shares rst_n_i and is reset too; no partial digest is delivered.
- rsp_data_o is 0 outside DRAIN.

Decomposition:
- Package sha256_pkg holds D_WIDTH=32, O_COUNT=8, and the state enum (IDLE, FEED, DRAIN).
- Sub-module rr_arbiter (parameter N_REQ):
  - Inputs: req vector and pointer.
  - Outputs: combinational one-hot/index grant plus any-request.
  - Reusable for other shared cores.

Test Plan:
- Requester 0 sends "abc" as one padded block (0x61626380, 14 x 0x00000000, 0x00000018, last on word 16) -> rsp_valid_o[0] carries exactly 8 words ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, then busy_o=0.
- Requesters 0, 1, 2 assert "abc" simultaneously from reset -> service order 0, 1, 2; identical digests on each lane; no word interleaving on core_in_data_o.
- Requester 3 just served, then 1 and 3 request together -> 1 granted first, then 3.
- rsp_ready_i[gnt] toggled 1-0-1 each cycle in DRAIN -> core_out_ready_o follows it; 8 words delivered in order; state stays DRAIN until the 8th handshake.
- Granted requester deasserts req_valid_i for 5 cycles mid-block -> core_in_valid_o=0 for those cycles; other requesters' req_ready_o stay 0; digest still correct.
- rst_n_i pulsed low during DRAIN after word 3 -> all outputs 0 asynchronously; after release, requester 0 wins the first arbitration and a fresh "abc" gives the correct digest.
